// File: rtl/ray_scheduler.sv
// Frame-level sequencer for ray_gen: walks pixels in raster order, issues one
// camera-space direction at a time and hands normalized rays to the marcher.
module ray_scheduler #(
    parameter int          H_PIXELS  = 320,
    parameter int          V_PIXELS  = 180,
    parameter int          PIX_SHIFT = 10,
    parameter logic [31:0] FOCAL     = 32'h0001_0000
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        frame_start_in,
    input  logic                        abort_in,
    output logic                        busy_out,
    output logic                        frame_done_out,
    output logic                        rg_start_out,
    output logic [31:0]                 rg_in_x_out,
    output logic [31:0]                 rg_in_y_out,
    output logic [31:0]                 rg_in_z_out,
    input  logic                        rg_done_in,
    input  logic [31:0]                 rg_out_x_in,
    input  logic [31:0]                 rg_out_y_in,
    input  logic [31:0]                 rg_out_z_in,
    output logic                        ray_valid_out,
    input  logic                        ray_ready_in,
    output logic [31:0]                 ray_x_out,
    output logic [31:0]                 ray_y_out,
    output logic [31:0]                 ray_z_out,
    output logic [$clog2(H_PIXELS)-1:0] ray_hcount_out,
    output logic [$clog2(V_PIXELS)-1:0] ray_vcount_out
);

    localparam int HW = $clog2(H_PIXELS);
    localparam int VW = $clog2(V_PIXELS);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        PRESENT
    } state_t;

    state_t        state;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic [HW-1:0] next_h;
    logic [VW-1:0] next_v;
    logic          last_col;
    logic          last_row;

    // Screen-centred offsets: x grows to the right, y grows upward.
    function automatic logic [31:0] dir_x(input logic [HW-1:0] h);
        dir_x = (int'(h) - H_PIXELS / 2) <<< PIX_SHIFT;
    endfunction

    function automatic logic [31:0] dir_y(input logic [VW-1:0] v);
        dir_y = (V_PIXELS / 2 - int'(v)) <<< PIX_SHIFT;
    endfunction

    always_comb begin
        last_col = (hcount == HW'(H_PIXELS - 1));
        last_row = (vcount == VW'(V_PIXELS - 1));
        next_h   = last_col ? '0 : hcount + 1'b1;
        next_v   = last_col ? vcount + 1'b1 : vcount;
    end

    assign busy_out = (state != IDLE);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state          <= IDLE;
            hcount         <= '0;
            vcount         <= '0;
            frame_done_out <= 1'b0;
            rg_start_out   <= 1'b0;
            rg_in_x_out    <= '0;
            rg_in_y_out    <= '0;
            rg_in_z_out    <= '0;
            ray_valid_out  <= 1'b0;
            ray_x_out      <= '0;
            ray_y_out      <= '0;
            ray_z_out      <= '0;
            ray_hcount_out <= '0;
            ray_vcount_out <= '0;
        end else begin
            // NOTE: pulse outputs default low here and are raised only by the
            // branch that needs them; a later NBA in the same block wins.
            rg_start_out   <= 1'b0;
            frame_done_out <= 1'b0;

            if (abort_in && state != IDLE) begin
                state         <= IDLE;
                ray_valid_out <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (frame_start_in) begin
                            hcount       <= '0;
                            vcount       <= '0;
                            rg_in_x_out  <= dir_x('0);
                            rg_in_y_out  <= dir_y('0);
                            rg_in_z_out  <= FOCAL;
                            rg_start_out <= 1'b1;
                            state        <= ISSUE;
                        end
                    end
                    ISSUE: state <= WAIT;
                    WAIT: begin
                        if (rg_done_in) begin
                            ray_x_out      <= rg_out_x_in;
                            ray_y_out      <= rg_out_y_in;
                            ray_z_out      <= rg_out_z_in;
                            ray_hcount_out <= hcount;
                            ray_vcount_out <= vcount;
                            ray_valid_out  <= 1'b1;
                            state          <= PRESENT;
                        end
                    end
                    PRESENT: begin
                        if (ray_ready_in) begin
                            ray_valid_out <= 1'b0;
                            if (last_col && last_row) begin
                                frame_done_out <= 1'b1;
                                state          <= IDLE;
                            end else begin
                                hcount       <= next_h;
                                vcount       <= next_v;
                                rg_in_x_out  <= dir_x(next_h);
                                rg_in_y_out  <= dir_y(next_v);
                                rg_in_z_out  <= FOCAL;
                                rg_start_out <= 1'b1;
                                state        <= ISSUE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ray_scheduler.sv
// Self-checking bench for ray_scheduler on a 4x2 frame: directed table, corner
// sequences and randomized frames against a raster-order reference model.
module tb_ray_scheduler;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int PS = 10;
    localparam int N  = H * V;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        frame_start_in;
    logic        abort_in;
    logic        busy_out;
    logic        frame_done_out;
    logic        rg_start_out;
    logic [31:0] rg_in_x_out, rg_in_y_out, rg_in_z_out;
    logic        rg_done_in;
    logic [31:0] rg_out_x_in, rg_out_y_in, rg_out_z_in;
    logic        ray_valid_out;
    logic        ray_ready_in;
    logic [31:0] ray_x_out, ray_y_out, ray_z_out;
    logic [1:0]  ray_hcount_out;
    logic [0:0]  ray_vcount_out;

    int checks = 0;
    int errors = 0;

    // ray_gen stand-in: done pulses rg_lat cycles after the start cycle
    logic        rg_auto;
    int          rg_lat;
    int          rg_cnt;
    logic [31:0] rg_vx, rg_vy, rg_vz;

    typedef struct {
        int          h;
        int          v;
        logic [31:0] x;
        logic [31:0] y;
    } vec_t;

    vec_t tbl[N];

    ray_scheduler #(
        .H_PIXELS (H),
        .V_PIXELS (V),
        .PIX_SHIFT(PS),
        .FOCAL    (32'h0001_0000)
    ) dut (
        .clk_in        (clk),
        .rst_in        (rst_in),
        .frame_start_in(frame_start_in),
        .abort_in      (abort_in),
        .busy_out      (busy_out),
        .frame_done_out(frame_done_out),
        .rg_start_out  (rg_start_out),
        .rg_in_x_out   (rg_in_x_out),
        .rg_in_y_out   (rg_in_y_out),
        .rg_in_z_out   (rg_in_z_out),
        .rg_done_in    (rg_done_in),
        .rg_out_x_in   (rg_out_x_in),
        .rg_out_y_in   (rg_out_y_in),
        .rg_out_z_in   (rg_out_z_in),
        .ray_valid_out (ray_valid_out),
        .ray_ready_in  (ray_ready_in),
        .ray_x_out     (ray_x_out),
        .ray_y_out     (ray_y_out),
        .ray_z_out     (ray_z_out),
        .ray_hcount_out(ray_hcount_out),
        .ray_vcount_out(ray_vcount_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to the next falling edge, then run the ray_gen stand-in.
    task automatic tick();
        @(negedge clk);
        if (rg_auto) begin
            rg_done_in = 1'b0;
            if (rg_start_out) begin
                rg_cnt = rg_lat;
            end else if (rg_cnt > 0) begin
                rg_cnt--;
                if (rg_cnt == 0) rg_done_in = 1'b1;
            end
            rg_out_x_in = rg_vx;
            rg_out_y_in = rg_vy;
            rg_out_z_in = rg_vz;
        end
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return rg_start_out;
            1:       return ray_valid_out;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int which, input string name);
        int n = 0;
        while (!sig(which) && n < 100) begin
            tick();
            n++;
        end
        check(name, 32'(sig(which)), 32'd1);
    endtask

    task automatic start_frame();
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
    endtask

    function automatic logic [31:0] model_x(input int p);
        return 32'(((p % H) - H / 2) * (1 << PS));
    endfunction

    function automatic logic [31:0] model_y(input int p);
        return 32'((V / 2 - p / H) * (1 << PS));
    endfunction

    initial begin
        int bad;
        int p;
        int n;
        logic hs_prev;
        logic frame_ok;
        logic ready;
        logic [31:0] sx, sh;

        tbl[0] = '{0, 0, 32'hFFFF_F800, 32'h0000_0400};
        tbl[1] = '{1, 0, 32'hFFFF_FC00, 32'h0000_0400};
        tbl[2] = '{2, 0, 32'h0000_0000, 32'h0000_0400};
        tbl[3] = '{3, 0, 32'h0000_0400, 32'h0000_0400};
        tbl[4] = '{0, 1, 32'hFFFF_F800, 32'h0000_0000};
        tbl[5] = '{1, 1, 32'hFFFF_FC00, 32'h0000_0000};
        tbl[6] = '{2, 1, 32'h0000_0000, 32'h0000_0000};
        tbl[7] = '{3, 1, 32'h0000_0400, 32'h0000_0000};

        rst_in = 1'b1;
        frame_start_in = 1'b0;
        abort_in = 1'b0;
        rg_done_in = 1'b0;
        rg_out_x_in = '0;
        rg_out_y_in = '0;
        rg_out_z_in = '0;
        ray_ready_in = 1'b1;
        rg_auto = 1'b1;
        rg_lat = 5;
        rg_cnt = 0;
        rg_vx = 32'd37837;
        rg_vy = 32'd37837;
        rg_vz = 32'd37837;

        // Reset state
        tick();
        tick();
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_valid", 32'(ray_valid_out), 32'd0);
        check("rst_start", 32'(rg_start_out), 32'd0);
        check("rst_done", 32'(frame_done_out), 32'd0);
        check("rst_rg_x", rg_in_x_out, 32'd0);
        rst_in = 1'b0;
        tick();

        // Full frame, ready held high, 5-cycle ray_gen latency
        start_frame();
        for (int i = 0; i < N; i++) begin
            wait_sig(0, "ff_start_seen");
            check("ff_issue_x", rg_in_x_out, tbl[i].x);
            check("ff_issue_y", rg_in_y_out, tbl[i].y);
            check("ff_issue_z", rg_in_z_out, 32'h0001_0000);
            tick();
            check("ff_start_one_cycle", 32'(rg_start_out), 32'd0);
            wait_sig(1, "ff_valid_seen");
            check("ff_ray_h", 32'(ray_hcount_out), 32'(tbl[i].h));
            check("ff_ray_v", 32'(ray_vcount_out), 32'(tbl[i].v));
            check("ff_ray_x", ray_x_out, 32'd37837);
            tick();
            check("ff_valid_drop", 32'(ray_valid_out), 32'd0);
            check("ff_frame_done", 32'(frame_done_out), (i == N - 1) ? 32'd1 : 32'd0);
        end
        check("ff_idle_busy", 32'(busy_out), 32'd0);
        tick();
        check("ff_done_one_cycle", 32'(frame_done_out), 32'd0);

        // Backpressure for 10 cycles in PRESENT
        ray_ready_in = 1'b0;
        start_frame();
        wait_sig(1, "bp_valid_seen");
        sx = ray_x_out;
        sh = 32'(ray_hcount_out);
        bad = 0;
        repeat (10) begin
            tick();
            if (ray_valid_out !== 1'b1 || rg_start_out !== 1'b0 || ray_x_out !== sx ||
                32'(ray_hcount_out) !== sh || ray_vcount_out !== 1'b0)
                bad++;
        end
        check("bp_hold", 32'(bad), 32'd0);
        ray_ready_in = 1'b1;
        tick();
        check("bp_valid_drop", 32'(ray_valid_out), 32'd0);
        check("bp_restart", 32'(rg_start_out), 32'd1);
        check("bp_next_x", rg_in_x_out, 32'hFFFF_FC00);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check("bp_abort_busy", 32'(busy_out), 32'd0);

        // Protocol abuse with manually driven ray_gen
        rg_auto = 1'b0;
        rg_cnt = 0;
        rg_done_in = 1'b0;
        ray_ready_in = 1'b0;
        tick();
        start_frame();
        check("ab_issue", 32'(rg_start_out), 32'd1);
        rg_out_x_in = 32'd111;
        rg_done_in = 1'b1;
        tick();
        rg_done_in = 1'b0;
        check("ab_done_in_issue", 32'(ray_valid_out), 32'd0);
        frame_start_in = 1'b1;
        tick();
        frame_start_in = 1'b0;
        check("ab_fs_wait_x", rg_in_x_out, 32'hFFFF_F800);
        check("ab_fs_wait_start", 32'(rg_start_out), 32'd0);
        rg_out_x_in = 32'd222;
        rg_done_in = 1'b1;
        tick();
        rg_done_in = 1'b0;
        check("ab_valid", 32'(ray_valid_out), 32'd1);
        check("ab_ray_x", ray_x_out, 32'd222);
        check("ab_ray_h", 32'(ray_hcount_out), 32'd0);
        rg_out_x_in = 32'd333;
        rg_done_in = 1'b1;
        tick();
        rg_done_in = 1'b0;
        check("ab_spur_present", ray_x_out, 32'd222);
        check("ab_spur_present_valid", 32'(ray_valid_out), 32'd1);
        ray_ready_in = 1'b1;
        tick();
        ray_ready_in = 1'b0;
        check("ab_next_x", rg_in_x_out, 32'hFFFF_FC00);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check("ab_abort_busy", 32'(busy_out), 32'd0);
        rg_out_x_in = 32'd444;
        rg_done_in = 1'b1;
        tick();
        rg_done_in = 1'b0;
        check("ab_spur_idle", ray_x_out, 32'd222);
        check("ab_spur_idle_valid", 32'(ray_valid_out), 32'd0);

        // Abort at pixel (2,0) during WAIT
        rg_auto = 1'b1;
        rg_lat = 5;
        rg_vx = 32'd37837;
        rg_vy = 32'd37837;
        rg_vz = 32'd37837;
        ray_ready_in = 1'b1;
        start_frame();
        n = 0;
        while (!(rg_start_out === 1'b1 && rg_in_x_out === 32'd0) && n < 200) begin
            tick();
            n++;
        end
        check("abt_reach_px2", 32'(rg_start_out), 32'd1);
        tick();
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        check("abt_busy", 32'(busy_out), 32'd0);
        check("abt_valid", 32'(ray_valid_out), 32'd0);
        check("abt_start", 32'(rg_start_out), 32'd0);
        check("abt_done", 32'(frame_done_out), 32'd0);
        bad = 0;
        repeat (8) begin
            tick();
            if (ray_valid_out !== 1'b0 || frame_done_out !== 1'b0 || busy_out !== 1'b0) bad++;
        end
        check("abt_late_done", 32'(bad), 32'd0);
        rg_lat = 20;
        start_frame();
        check("abt_restart", 32'(rg_start_out), 32'd1);
        check("abt_restart_x", rg_in_x_out, 32'hFFFF_F800);
        check("abt_restart_y", rg_in_y_out, 32'h0000_0400);

        // Asynchronous reset between edges, mid-WAIT
        tick();
        tick();
        #2;
        rst_in = 1'b1;
        #1;
        check("ar_busy", 32'(busy_out), 32'd0);
        check("ar_start", 32'(rg_start_out), 32'd0);
        check("ar_valid", 32'(ray_valid_out), 32'd0);
        check("ar_rg_x", rg_in_x_out, 32'd0);
        check("ar_rg_z", rg_in_z_out, 32'd0);
        check("ar_ray_x", ray_x_out, 32'd0);
        tick();
        rst_in = 1'b0;
        tick();
        start_frame();
        check("ar_restart", 32'(rg_start_out), 32'd1);
        check("ar_restart_x", rg_in_x_out, 32'hFFFF_F800);
        check("ar_restart_z", rg_in_z_out, 32'h0001_0000);
        abort_in = 1'b1;
        tick();
        abort_in = 1'b0;
        tick();

        // Randomized frames against the raster-order model
        for (int f = 0; f < 3; f++) begin
            p = 0;
            hs_prev = 1'b0;
            frame_ok = 1'b0;
            rg_lat = $urandom_range(1, 6);
            start_frame();
            for (int c = 0; c < 3000 && !frame_ok; c++) begin
                if (hs_prev) begin
                    check("rnd_valid_drop", 32'(ray_valid_out), 32'd0);
                    check("rnd_frame_done", 32'(frame_done_out), (p == N) ? 32'd1 : 32'd0);
                    if (p == N) frame_ok = 1'b1;
                    hs_prev = 1'b0;
                end
                if (!frame_ok) begin
                    if (rg_start_out) begin
                        check("rnd_issue_x", rg_in_x_out, model_x(p));
                        check("rnd_issue_y", rg_in_y_out, model_y(p));
                        rg_vx = $urandom;
                        rg_vy = $urandom;
                        rg_vz = $urandom;
                        rg_lat = $urandom_range(1, 6);
                    end
                    ready = ($urandom_range(0, 9) < 6);
                    ray_ready_in = ready;
                    if (ray_valid_out && ready) begin
                        check("rnd_ray_h", 32'(ray_hcount_out), 32'(p % H));
                        check("rnd_ray_v", 32'(ray_vcount_out), 32'(p / H));
                        check("rnd_ray_x", ray_x_out, rg_vx);
                        check("rnd_ray_y", ray_y_out, rg_vy);
                        check("rnd_ray_z", ray_z_out, rg_vz);
                        p++;
                        hs_prev = 1'b1;
                    end
                    tick();
                end
            end
            check("rnd_frame_complete", 32'(frame_ok), 32'd1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
